stream_aligner: RTL and testbench

Parametrised, handshaked pixel realigner for the draw pipeline. It accepts a stream of N_PIX-pixel beats and emits beats starting S pixels into the span, where S is any offset in 0..N_PIX-1 latched at span start. It carries the previous beat internally, so the upstream no longer has to present a double-width unaligned window. A span that ends partway through a beat produces a trailing flush beat. Sits between the pixel fetch stage and the line-buffer writer in the clk_draw domain.

---
 rtl/stream_aligner.sv | 168 ++++++++++++++++
 tb/tb_stream_aligner.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/stream_aligner.sv
// Handshaked pixel realigner: re-slices a stream of N_PIX-pixel beats so that
// each output beat starts S pixels into the span, with a trailing flush beat.
module stream_aligner #(
  parameter int PIX_W   = 9,
  parameter int N_PIX   = 8,
  parameter int SHIFT_W = $clog2(N_PIX)
) (
  input  logic                   clk_draw,
  input  logic                   rst_draw,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_PIX*PIX_W-1:0] in_pixels,
  input  logic [N_PIX-1:0]       in_mask,
  input  logic                   in_first,
  input  logic                   in_last,
  input  logic [SHIFT_W-1:0]     in_shift,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N_PIX*PIX_W-1:0] out_pixels,
  output logic [N_PIX-1:0]       out_mask,
  output logic                   out_last
);

  localparam int BW = N_PIX * PIX_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [BW-1:0]      prev_pix_q, prev_pix_d;
  logic [N_PIX-1:0]   prev_mask_q, prev_mask_d;
  logic               out_valid_q, out_valid_d;
  logic [BW-1:0]      out_pix_q, out_pix_d;
  logic [N_PIX-1:0]   out_mask_q, out_mask_d;
  logic               out_last_q, out_last_d;

  logic [BW-1:0]      cur_pix_s;
  logic [N_PIX-1:0]   cur_mask_s;
  logic [BW-1:0]      win_pix_s;
  logic [N_PIX-1:0]   win_mask_s;
  logic               out_free_s;
  logic               in_ready_s;
  logic               accept_s;
  logic               unused_first_s;

  // Every beat accepted in IDLE opens a span, so in_first carries no extra information.
  assign unused_first_s = in_first;

  // Current half of the window; the flush beat sees an empty current beat.
  always_comb begin
    cur_pix_s  = in_pixels;
    cur_mask_s = in_mask;
    if (state_q == FLUSH) begin
      cur_pix_s  = {BW{1'b0}};
      cur_mask_s = {N_PIX{1'b0}};
    end else begin
      cur_pix_s  = in_pixels;
      cur_mask_s = in_mask;
    end
  end

  assign win_pix_s  = BW'({cur_pix_s, prev_pix_q} >> (shift_q * PIX_W));
  assign win_mask_s = N_PIX'({cur_mask_s, prev_mask_q} >> shift_q);

  assign out_free_s = !out_valid_q || out_ready;
  assign in_ready_s = !rst_draw && (state_q != FLUSH) && out_free_s;
  assign accept_s   = in_valid && in_ready_s;

  // Span FSM and output-register load decisions.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    prev_pix_d  = prev_pix_q;
    prev_mask_d = prev_mask_q;
    out_valid_d = out_valid_q && !out_ready;
    out_pix_d   = out_pix_q;
    out_mask_d  = out_mask_q;
    out_last_d  = out_last_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          shift_d = in_shift;
          if (in_shift == {SHIFT_W{1'b0}}) begin
            out_valid_d = 1'b1;
            out_pix_d   = in_pixels;
            out_mask_d  = in_mask;
            out_last_d  = in_last;
            state_d     = in_last ? IDLE : RUN;
          end else begin
            prev_pix_d  = in_pixels;
            prev_mask_d = in_mask;
            state_d     = in_last ? FLUSH : RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (accept_s) begin
          out_valid_d = 1'b1;
          if (shift_q == {SHIFT_W{1'b0}}) begin
            out_pix_d  = in_pixels;
            out_mask_d = in_mask;
            out_last_d = in_last;
            state_d    = in_last ? IDLE : RUN;
          end else begin
            out_pix_d   = win_pix_s;
            out_mask_d  = win_mask_s;
            out_last_d  = 1'b0;
            prev_pix_d  = in_pixels;
            prev_mask_d = in_mask;
            state_d     = in_last ? FLUSH : RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        if (out_free_s) begin
          out_valid_d = 1'b1;
          out_pix_d   = win_pix_s;
          out_mask_d  = win_mask_s;
          out_last_d  = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d = FLUSH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any span in progress.
  always_ff @(posedge clk_draw or posedge rst_draw) begin
    if (rst_draw) begin
      state_q     <= IDLE;
      shift_q     <= {SHIFT_W{1'b0}};
      prev_pix_q  <= {BW{1'b0}};
      prev_mask_q <= {N_PIX{1'b0}};
      out_valid_q <= 1'b0;
      out_pix_q   <= {BW{1'b0}};
      out_mask_q  <= {N_PIX{1'b0}};
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      prev_pix_q  <= prev_pix_d;
      prev_mask_q <= prev_mask_d;
      out_valid_q <= out_valid_d;
      out_pix_q   <= out_pix_d;
      out_mask_q  <= out_mask_d;
      out_last_q  <= out_last_d;
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_q;
  assign out_pixels = out_pix_q;
  assign out_mask   = out_mask_q;
  assign out_last   = out_last_q;

endmodule

// File: tb/tb_stream_aligner.sv
// Directed bench for stream_aligner: cycle-by-cycle vector table plus a
// hand-written asynchronous reset sequence. Pixel value = stream index.
module tb_stream_aligner;

  localparam int PIX_W   = 9;
  localparam int N_PIX   = 8;
  localparam int SHIFT_W = 3;
  localparam int BW      = N_PIX * PIX_W;

  logic               clk_draw = 1'b0;
  logic               rst_draw = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [BW-1:0]      in_pixels = '0;
  logic [N_PIX-1:0]   in_mask = '0;
  logic               in_first = 1'b0;
  logic               in_last = 1'b0;
  logic [SHIFT_W-1:0] in_shift = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [BW-1:0]      out_pixels;
  logic [N_PIX-1:0]   out_mask;
  logic               out_last;

  int checks = 0;
  int failures = 0;

  always #5 clk_draw = ~clk_draw;

  stream_aligner #(.PIX_W(PIX_W), .N_PIX(N_PIX)) dut (
    .clk_draw  (clk_draw),
    .rst_draw  (rst_draw),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pixels (in_pixels),
    .in_mask   (in_mask),
    .in_first  (in_first),
    .in_last   (in_last),
    .in_shift  (in_shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pixels(out_pixels),
    .out_mask  (out_mask),
    .out_last  (out_last)
  );

  typedef struct {
    logic         v;
    int           ib;
    logic [7:0]   im;
    logic         f;
    logic         l;
    logic [2:0]   sh;
    logic         ordy;
    logic         erdy;
    logic         ev;
    int           eb;
    int           en;
    logic [7:0]   em;
    logic         el;
  } vec_t;

  vec_t vecs[$];

  // Lanes 0..n-1 hold base+lane, lanes above are zero.
  function automatic logic [BW-1:0] mk_pix(input int base, input int n);
    logic [BW-1:0] p;
    p = '0;
    for (int i = 0; i < N_PIX; i++) begin
      if (i < n) begin
        int t;
        t = base + i;
        p[i*PIX_W +: PIX_W] = t[PIX_W-1:0];
      end
    end
    return p;
  endfunction

  function automatic vec_t row(input logic v, input int ib, input logic [7:0] im,
                               input logic f, input logic l, input logic [2:0] sh,
                               input logic ordy, input logic erdy, input logic ev,
                               input int eb, input int en, input logic [7:0] em,
                               input logic el);
    vec_t r;
    r.v = v; r.ib = ib; r.im = im; r.f = f; r.l = l; r.sh = sh; r.ordy = ordy;
    r.erdy = erdy; r.ev = ev; r.eb = eb; r.en = en; r.em = em; r.el = el;
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input logic [BW-1:0] got,
                     input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=%h exp=%h", name, idx, got, exp);
    end
  endtask

  task automatic apply(input vec_t r, input int idx);
    @(negedge clk_draw);
    in_valid  = r.v;
    in_pixels = mk_pix(r.ib, N_PIX);
    in_mask   = r.im;
    in_first  = r.f;
    in_last   = r.l;
    in_shift  = r.sh;
    out_ready = r.ordy;
    #1;
    chk("in_ready", idx, BW'(in_ready), BW'(r.erdy));
    @(posedge clk_draw);
    #1;
    chk("out_valid", idx, BW'(out_valid), BW'(r.ev));
    if (r.ev) begin
      chk("out_pixels", idx, out_pixels, mk_pix(r.eb, r.en));
      chk("out_mask", idx, BW'(out_mask), BW'(r.em));
      chk("out_last", idx, BW'(out_last), BW'(r.el));
    end
  endtask

  initial begin
    // S=0, 3-beat span, passthrough
    vecs.push_back(row(1,  0, 8'hFF, 1, 0, 3'd0, 1, 1, 1,  0, 8, 8'hFF, 0));
    vecs.push_back(row(1,  8, 8'hFF, 0, 0, 3'd0, 1, 1, 1,  8, 8, 8'hFF, 0));
    vecs.push_back(row(1, 16, 8'hFF, 0, 1, 3'd0, 1, 1, 1, 16, 8, 8'hFF, 1));
    vecs.push_back(row(0,  0, 8'hFF, 0, 0, 3'd0, 1, 1, 0,  0, 0, 8'h00, 0));
    // S=3, 3-beat span with flush
    vecs.push_back(row(1,  0, 8'hFF, 1, 0, 3'd3, 1, 1, 0,  0, 0, 8'h00, 0));
    vecs.push_back(row(1,  8, 8'hFF, 0, 0, 3'd3, 1, 1, 1,  3, 8, 8'hFF, 0));
    vecs.push_back(row(1, 16, 8'hFF, 0, 1, 3'd3, 1, 1, 1, 11, 8, 8'hFF, 0));
    vecs.push_back(row(0,  0, 8'hFF, 0, 0, 3'd0, 1, 0, 1, 19, 5, 8'h1F, 1));
    vecs.push_back(row(0,  0, 8'hFF, 0, 0, 3'd0, 1, 1, 0,  0, 0, 8'h00, 0));
    // single-beat spans: S=7, then S=3 with mask 0xF0
    vecs.push_back(row(1,  0, 8'hFF, 1, 1, 3'd7, 1, 1, 0,  0, 0, 8'h00, 0));
    vecs.push_back(row(0,  0, 8'hFF, 0, 0, 3'd0, 1, 0, 1,  7, 1, 8'h01, 1));
    vecs.push_back(row(1,  0, 8'hF0, 1, 1, 3'd3, 1, 1, 0,  0, 0, 8'h00, 0));
    vecs.push_back(row(0,  0, 8'hFF, 0, 0, 3'd0, 1, 0, 1,  3, 5, 8'h1E, 1));
    vecs.push_back(row(0,  0, 8'hFF, 0, 0, 3'd0, 1, 1, 0,  0, 0, 8'h00, 0));
    // S=2 with out_ready low 5 cycles
    vecs.push_back(row(1,  0, 8'hFF, 1, 0, 3'd2, 1, 1, 0,  0, 0, 8'h00, 0));
    vecs.push_back(row(1,  8, 8'hFF, 0, 0, 3'd2, 1, 1, 1,  2, 8, 8'hFF, 0));
    for (int k = 0; k < 5; k++)
      vecs.push_back(row(1, 16, 8'hFF, 0, 1, 3'd2, 0, 0, 1, 2, 8, 8'hFF, 0));
    vecs.push_back(row(1, 16, 8'hFF, 0, 1, 3'd2, 1, 1, 1, 10, 8, 8'hFF, 0));
    vecs.push_back(row(0,  0, 8'hFF, 0, 0, 3'd0, 1, 0, 1, 18, 6, 8'h3F, 1));
    vecs.push_back(row(0,  0, 8'hFF, 0, 0, 3'd0, 1, 1, 0,  0, 0, 8'h00, 0));
    // back-to-back spans S=2 then S=5, next span offered during FLUSH
    vecs.push_back(row(1,  0, 8'hFF, 1, 0, 3'd2, 1, 1, 0,  0, 0, 8'h00, 0));
    vecs.push_back(row(1,  8, 8'hFF, 0, 1, 3'd2, 1, 1, 1,  2, 8, 8'hFF, 0));
    vecs.push_back(row(1,  0, 8'hFF, 1, 0, 3'd5, 1, 0, 1, 10, 6, 8'h3F, 1));
    vecs.push_back(row(1,  0, 8'hFF, 1, 0, 3'd5, 1, 1, 0,  0, 0, 8'h00, 0));
    vecs.push_back(row(1,  8, 8'hFF, 0, 1, 3'd2, 1, 1, 1,  5, 8, 8'hFF, 0));
    vecs.push_back(row(0,  0, 8'hFF, 0, 0, 3'd0, 1, 0, 1, 13, 3, 8'h07, 1));
    vecs.push_back(row(0,  0, 8'hFF, 0, 0, 3'd0, 1, 1, 0,  0, 0, 8'h00, 0));

    // power-on reset
    #1 rst_draw = 1'b1;
    #1;
    chk("rst_out_valid", 900, BW'(out_valid), '0);
    chk("rst_out_pixels", 900, out_pixels, '0);
    chk("rst_out_mask", 900, BW'(out_mask), '0);
    chk("rst_out_last", 900, BW'(out_last), '0);
    chk("rst_in_ready", 900, BW'(in_ready), '0);
    repeat (2) @(posedge clk_draw);
    @(negedge clk_draw);
    rst_draw = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // asynchronous reset mid-span (S=4, RUN, out_valid=1)
    @(negedge clk_draw);
    in_valid = 1'b1; in_pixels = mk_pix(0, N_PIX); in_mask = 8'hFF;
    in_first = 1'b1; in_last = 1'b0; in_shift = 3'd4; out_ready = 1'b1;
    @(negedge clk_draw);
    in_pixels = mk_pix(8, N_PIX); in_first = 1'b0;
    @(posedge clk_draw);
    #1;
    chk("pre_rst_out_valid", 901, BW'(out_valid), BW'(1'b1));
    chk("pre_rst_out_pixels", 901, out_pixels, mk_pix(4, N_PIX));
    @(negedge clk_draw);
    in_valid = 1'b0; out_ready = 1'b0;
    #2 rst_draw = 1'b1;
    #1;
    chk("arst_out_valid", 902, BW'(out_valid), '0);
    chk("arst_out_pixels", 902, out_pixels, '0);
    chk("arst_out_mask", 902, BW'(out_mask), '0);
    chk("arst_out_last", 902, BW'(out_last), '0);
    chk("arst_in_ready", 902, BW'(in_ready), '0);
    @(negedge clk_draw);
    rst_draw = 1'b0;
    // fresh single-beat span with S=1 must show no old prev data
    apply(row(1, 40, 8'hFF, 1, 1, 3'd1, 1, 1, 0,  0, 0, 8'h00, 0), 903);
    apply(row(0,  0, 8'hFF, 0, 0, 3'd0, 1, 0, 1, 41, 7, 8'h7F, 1), 904);
    apply(row(0,  0, 8'hFF, 0, 0, 3'd0, 1, 1, 0,  0, 0, 8'h00, 0), 905);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
